tdm_mux8: RTL
=============

Name: tdm_mux8

Overview:
- Sequential 8:1 time-division multiplexer, the transmit-side counterpart of Demux1_8.
- Accepts an 8-bit parallel word over a valid/ready handshake and emits its bits one lane at a time on a single line `y`.
- Drives lane index `s[2:0]` alongside `y`, so a downstream Demux1_8 fed with (i=y, s=s) routes each bit back to its original position.
- Back-to-back frames stream with no idle gap.

Parameters:
- HOLD, 1, cycles each lane is held on `y`/`s`; legal range 1..16.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  `d` holds a word to transmit.
- in_ready  output  1  block accepts `d` on this edge if in_valid=1.
- d  input  8  parallel word; bit k is emitted in lane k.
- y  output  1  serial data line; bit `s` of the captured word.
- s  output  3  current lane index, 0..7.
- y_valid  output  1  `y`/`s` carry frame data this cycle.
- frame_start  output  1  one-cycle pulse in the first cycle of lane 0.

Behaviour:
- Reset, when rst_n=0 at a rising edge:
  - State goes to IDLE; lane counter, hold counter and shadow register clear to 0.
  - Outputs: y=0, s=0, y_valid=0, frame_start=0, in_ready=1 (combinational from state; 1 in IDLE).
  - Reset mid-frame aborts the frame immediately. No partial lanes are emitted after the reset edge.
- States:
  - IDLE: in_ready=1, y_valid=0, y=0, s=0.
  - SEND: y_valid=1, s=lane, y=shadow[lane].
- Accept occurs on an edge where in_valid & in_ready:
  - shadow <= d, lane <= 0, hold <= 0, state <= SEND.
  - frame_start is registered; it is 1 in the cycle after the accept edge.
  - Latency: the accept edge is followed by lane 0 on the next cycle (one-cycle latency).
- SEND:
  - The hold counter increments every cycle.
  - When hold = HOLD-1: hold <= 0 and lane <= lane+1.
  - Lane 7 final hold cycle is the last cycle of the frame.
- in_ready in SEND is 1 only in the last cycle of the frame (lane=7, hold=HOLD-1); 0 otherwise.
- At the end of a frame:
  - If accepted: new shadow loaded, lane wraps to 0, SEND continues and frame_start pulses. No gap cycle; y_valid stays 1.
  - If not accepted: state goes to IDLE; y_valid=0 from the next cycle.
- `d` is sampled only on the accept edge. Later changes to `d` do not affect the frame in flight.
- in_valid is ignored whenever in_ready=0; no error or stall is signalled.
- The lane counter is 3 bits and wraps 7→0 only via the frame-end rule, never mid-frame.
- HOLD=1 gives 8 cycles per frame; in general a frame is 8*HOLD cycles.

Optional Feature:
- Macro: TDM_MUX8_PARITY_EN.
- Defined:
  - A 9th slot follows lane 7, held HOLD cycles, with s=0, y_valid=1, and y = even parity (XOR) of the shadow word.
  - Extra output port `par_slot` (1 bit) is 1 only during that slot.
  - in_ready and the end-of-frame decision move to the parity slot's last cycle.
  - Frame length becomes 9*HOLD cycles.
- Undefined: no par_slot port; behaviour exactly as above.

Test Plan:
- Reset, HOLD=1: hold rst_n=0 for 3 cycles with in_valid=1, d=8'hFF -> y=0, s=0, y_valid=0, in_ready=1, frame_start=0 throughout.
- Single frame, HOLD=1: accept d=8'hA5, then in_valid=0 -> cycles 1..8 give s=0..7 and y=1,0,1,0,0,1,0,1; frame_start=1 only in cycle 1; y_valid=0 and in_ready=1 from cycle 9.
- Back-to-back, HOLD=1: in_valid held 1 with d=8'h0F then 8'hF0 -> 16 consecutive y_valid=1 cycles; y=1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1; frame_start at cycles 1 and 9 only; in_ready=1 only at cycles 8 and 16 (and in IDLE).
- HOLD=3: accept d=8'h01 -> s=0 with y=1 for 3 cycles, then s=1..7 with y=0 for 3 cycles each; 24-cycle frame.
- Reset mid-frame, HOLD=1: accept 8'hFF, assert rst_n=0 at lane 4 -> y_valid=0, y=0, s=0 on the next cycle; after release, a new accept of 8'h80 starts at lane 0 with y=1 only at s=7.
- Loopback: connect y→i and s→s of a Demux1_8, and latch that demux's output bit `s` while y_valid=1 -> reconstructed byte equals each transmitted word for 8'h00, 8'hFF, 8'h5A, 8'hC3.
- With TDM_MUX8_PARITY_EN, HOLD=1: d=8'h07 -> slot 9 has par_slot=1, y=1; d=8'h03 -> slot 9 has y=0.

Source files
------------

// File: rtl/tdm_mux8.sv
// ---------------------------------------------------------------------------
// tdm_mux8 -- sequential 8:1 time-division multiplexer
//
// Purpose:
//   Takes an 8-bit parallel word over a valid/ready handshake and sends it
//   one bit per lane on the serial line y. The lane index s travels next to
//   y, so a downstream Demux1_8 fed with (i=y, s=s) puts every bit back in
//   its original position. Each lane is held for HOLD cycles. Frames can
//   follow each other with no idle gap: a new word is accepted in the last
//   cycle of the current frame.
//
// Parameters:
//   HOLD        cycles each lane stays on y/s (legal range 1..16)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   in_valid    d holds a word to transmit
//   in_ready    word is accepted on this edge if in_valid=1
//   d[7:0]      parallel word; bit k goes out in lane k
//   y           serial data, bit s of the captured word
//   s[2:0]      current lane index
//   y_valid     y/s carry frame data this cycle
//   frame_start one-cycle pulse in the first cycle of lane 0
//   par_slot    (TDM_MUX8_PARITY_EN only) high during the parity slot
//
// Build option:
//   TDM_MUX8_PARITY_EN  appends a ninth slot after lane 7. It carries the
//                       XOR of the captured word on y with s=0, and it is
//                       held for HOLD cycles. The handshake and the
//                       end-of-frame decision move to the last cycle of this
//                       slot.
// ---------------------------------------------------------------------------
module tdm_mux8 #(
  parameter int HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] d,
  output logic       y,
  output logic [2:0] s,
  output logic       y_valid,
  output logic       frame_start
`ifdef TDM_MUX8_PARITY_EN
  ,
  output logic       par_slot
`endif
);

  // The hold counter is 4 bits wide, which covers HOLD up to 16.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_PAR  = 2'd2
  } state_t;

  state_t      state_reg;
  logic [2:0]  lane_reg;
  logic [3:0]  hold_reg;
  logic [7:0]  shadow_reg;
  logic        frame_start_reg;

  logic        hold_done;
  logic        lane_last;
  logic        frame_end;
  logic        accept;

  assign hold_done = (hold_reg == HOLD_LAST);

  // Final cycle of lane 7.
  assign lane_last = (state_reg == ST_SEND) && (lane_reg == 3'd7) && hold_done;

`ifdef TDM_MUX8_PARITY_EN
  // The frame ends after the parity slot, not after lane 7.
  assign frame_end = (state_reg == ST_PAR) && hold_done;
`else
  assign frame_end = lane_last;
`endif

  // Ready in IDLE, or in the final cycle of a frame so frames can run back to back.
  assign in_ready = (state_reg == ST_IDLE) || frame_end;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      lane_reg        <= 3'd0;
      hold_reg        <= 4'd0;
      shadow_reg      <= 8'd0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= accept;
      if (accept) begin
        // Accept takes priority. At the end of a frame it restarts lane 0 in
        // place of the normal frame-end transition.
        shadow_reg <= d;
        lane_reg   <= 3'd0;
        hold_reg   <= 4'd0;
        state_reg  <= ST_SEND;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            lane_reg <= 3'd0;
            hold_reg <= 4'd0;
          end
          ST_SEND: begin
            if (hold_done) begin
              hold_reg <= 4'd0;
              if (lane_reg == 3'd7) begin
                // Lane 7 does not wrap here. Its next step is the parity slot
                // or the end of the frame.
                lane_reg <= 3'd0;
`ifdef TDM_MUX8_PARITY_EN
                state_reg <= ST_PAR;
`else
                state_reg <= ST_IDLE;
`endif
              end else begin
                lane_reg <= lane_reg + 3'd1;
              end
            end else begin
              hold_reg <= hold_reg + 4'd1;
            end
          end
`ifdef TDM_MUX8_PARITY_EN
          ST_PAR: begin
            if (hold_done) begin
              hold_reg  <= 4'd0;
              state_reg <= ST_IDLE;
            end else begin
              hold_reg <= hold_reg + 4'd1;
            end
          end
`endif
          default: begin
            state_reg <= ST_IDLE;
            lane_reg  <= 3'd0;
            hold_reg  <= 4'd0;
          end
        endcase
      end
    end
  end

  // The output decode uses only registered state, so y/s/y_valid change on
  // the clock edge and do not depend on the current inputs.
  always_comb begin
    y       = 1'b0;
    s       = 3'd0;
    y_valid = 1'b0;
`ifdef TDM_MUX8_PARITY_EN
    par_slot = 1'b0;
`endif
    case (state_reg)
      ST_SEND: begin
        y_valid = 1'b1;
        s       = lane_reg;
        y       = shadow_reg[lane_reg];
      end
`ifdef TDM_MUX8_PARITY_EN
      ST_PAR: begin
        y_valid  = 1'b1;
        s        = 3'd0;
        y        = ^shadow_reg;
        par_slot = 1'b1;
      end
`endif
      default: begin
        y       = 1'b0;
        s       = 3'd0;
        y_valid = 1'b0;
      end
    endcase
  end

  assign frame_start = frame_start_reg;

endmodule
